// File: rtl/cmip_fifo_rr_drain_sch.sv
// Round-robin burst drain scheduler over CH_NUM FWFT FIFOs with a single downstream stream.
// Optional compile macro CMIP_SCH_FLUSH_EN adds an idle-timeout flush of partial bursts.
module cmip_fifo_rr_drain_sch #(
  parameter int CH_NUM    = 4,
  parameter int DATA_WD   = 512,
  parameter int CNT_WD    = 6,
  parameter int BURST_LEN = 8,
  parameter int FLUSH_TO  = 256
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_en,
  input  logic [CH_NUM-1:0]                               i_ch_empty,
  input  logic [CH_NUM*CNT_WD-1:0]                        i_ch_rd_cnt,
  input  logic [CH_NUM*DATA_WD-1:0]                       i_ch_dout,
  output logic [CH_NUM-1:0]                               o_ch_rd,
  output logic                                            o_dat_vld,
  input  logic                                            i_dat_rdy,
  output logic [DATA_WD-1:0]                              o_dat,
  output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0]  o_dat_ch,
  output logic                                            o_sop,
  output logic                                            o_eop,
  output logic                                            o_busy
);

  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BL_W  = $clog2(BURST_LEN + 1);
  localparam int LEN_W = (CNT_WD > BL_W) ? CNT_WD : BL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;

  logic [CH_NUM-1:0] elig_s;
  logic [CH_W:0]     pick_s;
  logic              in_xfer_s;
  logic              vld_s;
  logic              xfer_s;
  logic              eop_s;
  logic [CH_W-1:0]   dat_sel_s;

  // First requester at or after last+1, wrapping; MSB of the result flags a hit.
  function automatic logic [CH_W:0] rr_pick(input logic [CH_NUM-1:0] req,
                                            input logic [CH_W-1:0]   last);
    logic [CH_W:0] res;
    int            idx;
    res = '0;
    for (int off = CH_NUM; off >= 1; off--) begin
      idx = (int'(last) + off) % CH_NUM;
      if (req[CH_W'(idx)]) begin
        res = {1'b1, CH_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  always_comb begin
    elig_s = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      elig_s[k] = LEN_W'(i_ch_rd_cnt[k*CNT_WD +: CNT_WD]) >= LEN_W'(BURST_LEN);
    end
  end

  assign pick_s = rr_pick(elig_s, last_grant_q);

`ifdef CMIP_SCH_FLUSH_EN
  localparam int TMR_W = $clog2(FLUSH_TO + 1);

  logic [TMR_W-1:0]  flush_tmr_q, flush_tmr_d;
  logic [CH_NUM-1:0] part_s;
  logic [CH_W:0]     flush_pick_s;
  logic              flush_go_s;

  always_comb begin
    part_s = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      part_s[k] = (i_ch_rd_cnt[k*CNT_WD +: CNT_WD] != '0) && !i_ch_empty[k];
    end
  end

  assign flush_pick_s = rr_pick(part_s, last_grant_q);
  assign flush_go_s   = (state_q == S_ARB) && i_en && !pick_s[CH_W] &&
                        (flush_tmr_q == TMR_W'(FLUSH_TO)) && flush_pick_s[CH_W];

  // Idle timer saturates at FLUSH_TO; any grant, i_en low or leaving ARB clears it.
  always_comb begin
    flush_tmr_d = '0;
    if ((state_q == S_ARB) && i_en && !pick_s[CH_W] && !flush_go_s) begin
      flush_tmr_d = (flush_tmr_q == TMR_W'(FLUSH_TO)) ? flush_tmr_q : flush_tmr_q + TMR_W'(1);
    end else begin
      flush_tmr_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_tmr_q <= '0;
    end else begin
      flush_tmr_q <= flush_tmr_d;
    end
  end
`endif

  assign in_xfer_s = (state_q == S_XFER);
  assign vld_s     = in_xfer_s && !i_ch_empty[grant_q];
  assign xfer_s    = vld_s && i_dat_rdy;
  assign eop_s     = vld_s && (beat_q == len_q - LEN_W'(1));
  assign dat_sel_s = in_xfer_s ? grant_q : '0;

  always_comb begin
    o_ch_rd   = xfer_s ? (CH_NUM'(1) << grant_q) : '0;
    o_dat_vld = vld_s;
    o_dat     = i_ch_dout[int'(dat_sel_s)*DATA_WD +: DATA_WD];
    o_dat_ch  = grant_q;
    o_sop     = vld_s && (beat_q == '0);
    o_eop     = eop_s;
    o_busy    = (state_q != S_IDLE);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_d       = beat_q;
    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARB: begin
        if (!i_en) begin
          state_d = S_IDLE;
        end else if (pick_s[CH_W]) begin
          grant_d      = pick_s[CH_W-1:0];
          last_grant_d = pick_s[CH_W-1:0];
          len_d        = LEN_W'(BURST_LEN);
          state_d      = S_XFER;
`ifdef CMIP_SCH_FLUSH_EN
        end else if (flush_go_s) begin
          grant_d      = flush_pick_s[CH_W-1:0];
          last_grant_d = flush_pick_s[CH_W-1:0];
          len_d        = LEN_W'(i_ch_rd_cnt[int'(flush_pick_s[CH_W-1:0])*CNT_WD +: CNT_WD]);
          state_d      = S_XFER;
`endif
        end else begin
          state_d = S_ARB;
        end
      end
      S_XFER: begin
        // i_en is only consulted at eop so a started burst always completes.
        if (xfer_s && eop_s) begin
          beat_d  = '0;
          state_d = i_en ? S_ARB : S_IDLE;
        end else if (xfer_s) begin
          beat_d = beat_q + LEN_W'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(CH_NUM - 1);
      len_q        <= LEN_W'(BURST_LEN);
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
    end
  end

endmodule

// File: tb/tb_cmip_fifo_rr_drain_sch.sv
// Scoreboard bench for cmip_fifo_rr_drain_sch: behavioural FWFT FIFOs feed the DUT and
// expected beats are queued when stimulus is loaded, then compared on each transfer.
module tb_cmip_fifo_rr_drain_sch;

  localparam int CH_NUM    = 4;
  localparam int DATA_WD   = 512;
  localparam int CNT_WD    = 6;
  localparam int BURST_LEN = 8;
  localparam int FLUSH_TO  = 256;
  localparam int CH_W      = 2;

  logic                        i_clk;
  logic                        i_rst_n;
  logic                        i_en;
  logic [CH_NUM-1:0]           i_ch_empty;
  logic [CH_NUM*CNT_WD-1:0]    i_ch_rd_cnt;
  logic [CH_NUM*DATA_WD-1:0]   i_ch_dout;
  logic [CH_NUM-1:0]           o_ch_rd;
  logic                        o_dat_vld;
  logic                        i_dat_rdy;
  logic [DATA_WD-1:0]          o_dat;
  logic [CH_W-1:0]             o_dat_ch;
  logic                        o_sop;
  logic                        o_eop;
  logic                        o_busy;

  cmip_fifo_rr_drain_sch #(
    .CH_NUM(CH_NUM), .DATA_WD(DATA_WD), .CNT_WD(CNT_WD),
    .BURST_LEN(BURST_LEN), .FLUSH_TO(FLUSH_TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_ch_empty(i_ch_empty),
    .i_ch_rd_cnt(i_ch_rd_cnt), .i_ch_dout(i_ch_dout), .o_ch_rd(o_ch_rd),
    .o_dat_vld(o_dat_vld), .i_dat_rdy(i_dat_rdy), .o_dat(o_dat), .o_dat_ch(o_dat_ch),
    .o_sop(o_sop), .o_eop(o_eop), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DATA_WD-1:0] dat;
    int                 ch;
    logic               sop;
    logic               eop;
  } beat_t;

  beat_t              sb[$];
  logic [DATA_WD-1:0] fq[CH_NUM][$];
  int                 wr_seq[CH_NUM];
  int                 exp_seq[CH_NUM];
  int                 pop_cnt[CH_NUM];
  int                 n_cmp;
  int                 n_err;
  bit                 rdy_toggle;

  function automatic logic [DATA_WD-1:0] mk_dat(input int ch, input int seq);
    logic [DATA_WD-1:0] d;
    d = '0;
    d[31:0] = 32'(ch * 65536 + seq);
    d[DATA_WD-1 -: 32] = 32'hA500_0000 | 32'(seq * 7 + ch);
    return d;
  endfunction

  task automatic chk_eq(input string tag, input logic [DATA_WD-1:0] act,
                        input logic [DATA_WD-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_ins();
    for (int k = 0; k < CH_NUM; k++) begin
      i_ch_empty[k] = (fq[k].size() == 0);
      i_ch_rd_cnt[k*CNT_WD +: CNT_WD] = CNT_WD'(fq[k].size());
      i_ch_dout[k*DATA_WD +: DATA_WD] = (fq[k].size() != 0) ? fq[k][0] : '0;
    end
  endtask

  task automatic load(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      fq[ch].push_back(mk_dat(ch, wr_seq[ch]));
      wr_seq[ch]++;
    end
    drive_ins();
  endtask

  task automatic exp_beats(input int ch, input int len, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.dat = mk_dat(ch, exp_seq[ch]);
      b.ch  = ch;
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      sb.push_back(b);
      exp_seq[ch]++;
    end
  endtask

  task automatic step();
    beat_t             e;
    logic [CH_NUM-1:0] popmask;
    @(negedge i_clk);
    popmask = o_ch_rd;
    if (o_dat_vld && i_dat_rdy) begin
      if (sb.size() == 0) begin
        chk_eq("unexpected_beat", DATA_WD'(o_dat_ch), DATA_WD'(32'hFFFF));
      end else begin
        e = sb.pop_front();
        chk_eq("dat", o_dat, e.dat);
        chk_eq("dat_ch", DATA_WD'(o_dat_ch), DATA_WD'(e.ch));
        chk_eq("sop", DATA_WD'(o_sop), DATA_WD'(e.sop));
        chk_eq("eop", DATA_WD'(o_eop), DATA_WD'(e.eop));
        chk_eq("ch_rd", DATA_WD'(o_ch_rd), DATA_WD'(1) << e.ch);
      end
    end else begin
      chk_eq("ch_rd_nobeat", DATA_WD'(o_ch_rd), DATA_WD'(0));
    end
    @(posedge i_clk);
    #1;
    for (int k = 0; k < CH_NUM; k++) begin
      if (popmask[k] && fq[k].size() != 0) begin
        void'(fq[k].pop_front());
        pop_cnt[k]++;
      end
    end
    if (rdy_toggle) i_dat_rdy = ~i_dat_rdy;
    drive_ins();
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk_eq("drain_timeout", DATA_WD'(sb.size()), DATA_WD'(0));
  endtask

  task automatic run_until_pops(input int ch, input int target, input int budget);
    int n;
    n = 0;
    while (pop_cnt[ch] < target && n < budget) begin
      step();
      n++;
    end
    chk_eq("pop_timeout", DATA_WD'(pop_cnt[ch]), DATA_WD'(target));
  endtask

  task automatic chk_idle(input string tag);
    chk_eq({tag, "_vld"},  DATA_WD'(o_dat_vld), DATA_WD'(0));
    chk_eq({tag, "_rd"},   DATA_WD'(o_ch_rd),   DATA_WD'(0));
    chk_eq({tag, "_sop"},  DATA_WD'(o_sop),     DATA_WD'(0));
    chk_eq({tag, "_eop"},  DATA_WD'(o_eop),     DATA_WD'(0));
    chk_eq({tag, "_busy"}, DATA_WD'(o_busy),    DATA_WD'(0));
    chk_eq({tag, "_ch"},   DATA_WD'(o_dat_ch),  DATA_WD'(0));
  endtask

  initial begin
    int order[8];
    n_cmp      = 0;
    n_err      = 0;
    rdy_toggle = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      wr_seq[k]  = 0;
      exp_seq[k] = 0;
      pop_cnt[k] = 0;
    end
    i_rst_n   = 1'b0;
    i_en      = 1'b0;
    i_dat_rdy = 1'b1;
    drive_ins();
    repeat (3) @(posedge i_clk);
    #1;
    chk_idle("rst");
    i_rst_n = 1'b1;
    step();
    step();
    chk_eq("idle_busy", DATA_WD'(o_busy), DATA_WD'(0));

    // single full burst from ch1
    load(1, 8);
    exp_beats(1, 8, 8);
    i_en = 1'b1;
    run_until_empty(50);
    chk_eq("ch1_pops", DATA_WD'(pop_cnt[1]), DATA_WD'(8));

    // all channels loaded: round-robin continues after ch1
    for (int c = 0; c < CH_NUM; c++) load(c, 16);
    order = '{2, 3, 0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 8; i++) exp_beats(order[i], 8, 8);
    run_until_empty(300);

    // ready toggling every cycle during a ch2 burst
    load(2, 8);
    exp_beats(2, 8, 8);
    rdy_toggle = 1'b1;
    i_dat_rdy  = 1'b0;
    run_until_empty(100);
    rdy_toggle = 1'b0;
    i_dat_rdy  = 1'b1;
    chk_eq("ch2_pops", DATA_WD'(pop_cnt[2]), DATA_WD'(24));

    // enable dropped at beat 3 of a ch3 burst; ch1 must not be granted afterwards
    i_en = 1'b0;
    repeat (3) step();
    load(3, 8);
    load(1, 8);
    exp_beats(3, 8, 8);
    i_en = 1'b1;
    run_until_pops(3, 19, 50);
    i_en = 1'b0;
    run_until_empty(50);
    repeat (4) step();
    chk_eq("en_drop_busy", DATA_WD'(o_busy), DATA_WD'(0));
    chk_eq("en_drop_ch1_left", DATA_WD'(fq[1].size()), DATA_WD'(8));

    // reset at beat 4 of a ch2 burst, then restart from channel 0
    load(2, 8);
    exp_beats(1, 8, 8);
    exp_beats(2, 8, 4);
    i_en = 1'b1;
    run_until_pops(2, 28, 100);
    i_rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    sb.delete();
    load(1, 8);
    load(3, 8);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    exp_beats(1, 8, 8);
    exp_beats(3, 8, 8);
    run_until_empty(100);
    chk_eq("rst_ch2_left", DATA_WD'(fq[2].size()), DATA_WD'(4));

    // ch2 holds a partial burst of 4
`ifdef CMIP_SCH_FLUSH_EN
    exp_beats(2, 4, 4);
    run_until_empty(FLUSH_TO + 100);
    chk_eq("flush_ch2_left", DATA_WD'(fq[2].size()), DATA_WD'(0));
`else
    repeat (FLUSH_TO + 50) step();
    chk_eq("noflush_ch2_left", DATA_WD'(fq[2].size()), DATA_WD'(4));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmip_fifo_rr_drain_sch.md
CMIP_FIFO_RR_DRAIN_SCH -- requirements
Module: cmip_fifo_rr_drain_sch

Interface
REQ-001 Parameters SHALL be: CH_NUM, default 4, number of source FIFO channels; DATA_WD, default 512, channel read-data width; CNT_WD, default 6, width of each channel read-count; BURST_LEN, default 8, beats per full burst; FLUSH_TO, default 256, idle cycles before a partial-burst flush.
REQ-002 Ports SHALL be, in this order:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  scheduler enable.
- i_ch_empty  in  CH_NUM  per-channel FWFT FIFO empty.
- i_ch_rd_cnt  in  CH_NUM*CNT_WD  per-channel read count; channel k at [k*CNT_WD +: CNT_WD].
- i_ch_dout  in  CH_NUM*DATA_WD  per-channel FWFT data; channel k at [k*DATA_WD +: DATA_WD].
- o_ch_rd  out  CH_NUM  per-channel pop strobe.
- o_dat_vld  out  1  downstream beat valid.
- i_dat_rdy  in  1  downstream ready.
- o_dat  out  DATA_WD  beat data.
- o_dat_ch  out  clog2(CH_NUM)  channel of current burst.
- o_sop  out  1  first beat of burst.
- o_eop  out  1  last beat of burst.
- o_busy  out  1  FSM not in IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, ARB and XFER.
REQ-004 A channel SHALL be eligible when its i_ch_rd_cnt >= BURST_LEN.
REQ-005 IDLE SHALL go to ARB when i_en=1; otherwise it SHALL stay in IDLE.
REQ-006 ARB SHALL scan channels round-robin, starting at (last_grant+1) mod CH_NUM, and grant the first eligible channel.
- On a grant, ARB SHALL latch the grant and burst length, then go to XFER on the next cycle.
- With no eligible channel, ARB SHALL stay in ARB.
- If i_en=0, ARB SHALL go to IDLE.
REQ-007 last_grant SHALL reset to CH_NUM-1, so channel 0 has first priority after reset.
REQ-008 In XFER, the following SHALL hold:
- o_dat_vld = ~i_ch_empty[grant], combinational.
- o_dat = i_ch_dout[grant], combinational.
- o_ch_rd[grant] = o_dat_vld & i_dat_rdy; every other o_ch_rd bit SHALL be 0.
REQ-009 A beat SHALL transfer only when o_dat_vld=1 and i_dat_rdy=1; the beat counter SHALL increment only on a transfer.
REQ-010 o_sop SHALL be high while beat counter=0; o_eop SHALL be high while beat counter=burst length-1; both SHALL be qualified by o_dat_vld.
REQ-011 On the eop transfer, XFER SHALL go to ARB if i_en=1, else to IDLE; the beat counter SHALL clear.
REQ-012 Deasserting i_en mid-burst SHALL NOT truncate the burst.
REQ-013 The empty FIFO of the granted channel mid-burst SHALL stall the burst (o_dat_vld=0) with no pop and no counter change.
REQ-014 Outside XFER: o_dat_vld=0, o_ch_rd=0, o_sop=0, o_eop=0, and o_dat SHALL hold the channel-0 data.
REQ-015 o_dat_ch SHALL equal the latched grant, valid from the ARB grant cycle until the next grant.
REQ-016 At most one bit of o_ch_rd SHALL be high in any cycle.

Reset
REQ-017 On i_rst_n=0, asynchronously:
- state=IDLE, beat counter=0, last_grant=CH_NUM-1, flush timer=0.
- All outputs 0: o_ch_rd, o_dat_vld, o_sop, o_eop, o_busy, o_dat_ch.
REQ-018 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from channel 0 with no partial pop.

Configuration
REQ-019 Macro CMIP_SCH_FLUSH_EN SHALL be the sole compile option.
REQ-020 With CMIP_SCH_FLUSH_EN defined:
- In ARB, a timer SHALL count cycles with i_en=1 and no eligible channel.
- On reaching FLUSH_TO, the timer SHALL grant, in round-robin order, the first channel with i_ch_rd_cnt>0 and i_ch_empty=0, with burst length = that channel's i_ch_rd_cnt latched at grant.
- The timer SHALL clear on any grant or when i_en=0.
REQ-021 Without CMIP_SCH_FLUSH_EN, only full BURST_LEN bursts SHALL be issued, and no timer logic SHALL be present.

Verification
REQ-022 Ch1 rd_cnt=8, others 0, i_en=1, i_dat_rdy=1 -> grant ch1; 8 consecutive beats; o_sop on beat 0, o_eop on beat 7; o_ch_rd[1] pulsed 8 times; o_dat_ch=1.
REQ-023 All 4 channels with rd_cnt>=16 -> burst order 0,1,2,3,0,...; no channel granted twice before the others are served.
REQ-024 i_dat_rdy toggled 1,0,1,0 during a ch2 burst -> pops only on rdy=1 cycles; data order preserved; still exactly 8 beats.
REQ-025 i_en dropped at beat 3 -> burst completes to eop, then o_busy=0; no new grant.
REQ-026 i_rst_n pulsed at beat 4 -> all outputs 0 immediately; after release, the first grant goes to the lowest eligible channel.
REQ-027 With CMIP_SCH_FLUSH_EN, FLUSH_TO=256, ch3 rd_cnt=3 -> after 256 idle ARB cycles, a 3-beat burst from ch3 with o_eop on beat 2; without the macro -> no burst.
